cplx_corr_stats: RTL
====================

// Module: cplx_corr_stats
// PURPOSE
//   Parametrised two-mode burst processor with one input burst in and one result burst out.
//   Mode 0: linear correlation conj(A)*B of two N-term complex vectors.
//   Mode 1: max/min/range of all 4-bit nibbles in an arbitrary-length burst.
//   Sits between a word-serial source and a consumer that can stall the output (out_ready).
// PARAMETERS
//   DW  8  bits per real/imag component (signed two's complement, even, >=4)
//   N   2  complex terms per vector in mode 0 (>=1)
//   derived: RW = 2*DW + $clog2(2*N); OW = 2*RW
// PORTS
//   clk        in   1       clock, all state on rising edge
//   rst_n      in   1       reset, asynchronous, active-low
//   in_valid   in   1       input beat valid; a burst is a run of consecutive valid cycles
//   in_mode    in   1       0=correlation, 1=nibble stats; sampled on first beat only
//   in         in   2*DW    beat; mode 0: {re[2DW-1:DW], im[DW-1:0]}
//   in_ready   out  1       1 in IDLE/LOAD; beats with in_ready=0 are dropped
//   out_valid  out  1       result word valid
//   out_ready  in   1       consumer accepts word when out_valid&&out_ready
//   out        out  OW      mode 0: {re[OW-1:RW], im[RW-1:0]} signed; mode 1: zero-extended 4 bits
//   out_last   out  1       high with the final word of a result burst
//   err        out  1       one-cycle pulse: malformed mode-0 burst discarded
// BEHAVIOUR
//   Reset: state IDLE; out_valid=0, out=0, out_last=0, err=0, in_ready=1; counters, max=0, min=15.
//   States IDLE -> LOAD -> (CALC, mode 0) -> OUT -> IDLE.
//   IDLE: first in_valid beat latches mode, stores beat as index 0, goes LOAD.
//   LOAD: each in_valid beat stored/accumulated; first cycle with in_valid=0 ends burst.
//     Mode 0: beats 0..N-1 are A[0..N-1], beats N..2N-1 are B[0..N-1].
//     Mode 0 count != 2N at burst end -> err=1 that cycle, buffers cleared, go IDLE, no output.
//     Mode 0 beats beyond 2N are not stored; they force err at burst end.
//     Mode 1: every nibble of every beat updates max/min (unsigned); no length limit, no storage.
//   CALC (mode 0): one (i,j) pair per cycle, i,j in 0..N-1 i-major; N*N cycles; k=i+j:
//     R[k] += Ar[i]*Br[j] + Ai[i]*Bi[j];  I[k] += Ar[i]*Bi[j] - Ai[i]*Br[j]
//     products sign-extended to RW; accumulators cleared on CALC entry; no overflow possible.
//   OUT: mode 0 emits R/I[0..2N-2] (2N-1 words); mode 1 emits max, min, max-min (3 words).
//     First out_valid: mode 0 N*N+1 cycles after burst-end cycle; mode 1 cycle after burst end.
//     out/out_valid/out_last held stable while out_ready=0; next word the cycle after handshake.
//     Handshake on out_last -> next cycle IDLE, out_valid=0, out=0, max=0, min=15, in_ready=1.
//   in_ready=0 in CALC and OUT; in_valid there is ignored (no buffering).
//   in_mode ignored on every beat except the first.
//   rst_n low mid-burst/CALC/OUT: immediate return to reset values, partial results lost.
// TESTING  (DW=8, N=2 unless noted)
//   Mode 0: A=(1+2j),(3+4j) B=(5+6j),(7+8j), out_ready=1
//     -> out {17,-4},{62,-8},{53,-4}, out_last on 3rd word, first out_valid 5 cycles after burst end.
//   Mode 0 extremes: all 8 components = -128 -> out {32768,0},{65536,0},{32768,0}.
//   Mode 1: beats 16'h1F3A,16'h0042 -> out 15, 0, 15; then beat 16'h7777 -> 7, 7, 0 (stats reset).
//   Backpressure: correlation case with out_ready low 3 cycles on word 1
//     -> word 1 held stable; order and values unchanged.
//   Malformed: mode 0 burst of 3 beats, then of 5 beats
//     -> err pulse each, out_valid stays 0; next legal burst correct.
//   Async reset mid-CALC with N=3
//     -> all outputs 0 immediately, in_ready=1; next burst processed correctly.

Source files
------------

// File: rtl/cplx_corr_stats.sv
// Two-mode burst processor: complex linear correlation conj(A)*B of two N-term
// vectors (mode 0) or max/min/range of all nibbles in a burst (mode 1).
module cplx_corr_stats #(
    parameter  int DW = 8,
    parameter  int N  = 2,
    localparam int RW = 2*DW + $clog2(2*N),
    localparam int OW = 2*RW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            in_mode,
    input  logic [2*DW-1:0] in,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OW-1:0]   out,
    output logic            out_last,
    output logic            err
);

    localparam int BW   = 2*DW;
    localparam int NB   = 2*N;
    localparam int NW   = 2*N - 1;
    localparam int CW   = $clog2(NB + 2);
    localparam int IW   = $clog2(N + 1);
    localparam int XW   = $clog2(NB) + 1;
    localparam int NNIB = BW / 4;

    localparam logic [CW-1:0] CNT_FULL = CW'(NB);
    localparam logic [CW-1:0] CNT_SAT  = CW'(NB + 1);
    localparam logic [IW-1:0] I_LAST   = IW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_OUT} state_t;
    state_t state, state_nxt;

    logic                 mode;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        beat_buf [NB];
    logic [IW-1:0]        ci, cj;
    logic signed [RW-1:0] acc_re [NW];
    logic signed [RW-1:0] acc_im [NW];
    logic [3:0]           st_max, st_min;
    logic [3:0]           st_max_nxt, st_min_nxt;
    logic [XW-1:0]        oidx;
    logic [XW-1:0]        oidx_last;

    // Running nibble statistics including the current beat.
    always_comb begin
        st_max_nxt = st_max;
        st_min_nxt = st_min;
        for (int unsigned q = 0; q < NNIB; q++) begin
            if (in[q*4 +: 4] > st_max_nxt) st_max_nxt = in[q*4 +: 4];
            if (in[q*4 +: 4] < st_min_nxt) st_min_nxt = in[q*4 +: 4];
        end
    end

    logic [BW-1:0] a_sel, b_sel;
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned m = 0; m < N; m++) begin
            if (ci == IW'(m)) a_sel = beat_buf[m];
            if (cj == IW'(m)) b_sel = beat_buf[N + m];
        end
    end

    logic signed [DW-1:0] ar, ai, br, bi;
    logic signed [BW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [RW-1:0] t_re, t_im;

    assign ar   = a_sel[BW-1:DW];
    assign ai   = a_sel[DW-1:0];
    assign br   = b_sel[BW-1:DW];
    assign bi   = b_sel[DW-1:0];
    assign p_rr = ar * br;
    assign p_ii = ai * bi;
    assign p_ri = ar * bi;
    assign p_ir = ai * br;
    assign t_re = {{(RW-BW){p_rr[BW-1]}}, p_rr} + {{(RW-BW){p_ii[BW-1]}}, p_ii};
    assign t_im = {{(RW-BW){p_ri[BW-1]}}, p_ri} - {{(RW-BW){p_ir[BW-1]}}, p_ir};

    assign oidx_last = mode ? XW'(2) : XW'(NW - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err       = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (!in_valid) begin
                    if (mode)                  state_nxt = S_OUT;
                    else if (cnt == CNT_FULL)  state_nxt = S_CALC;
                    else begin
                        err       = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_CALC: begin
                if (ci == I_LAST && cj == I_LAST) state_nxt = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                out_last  = (oidx == oidx_last);
                if (out_ready && out_last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        out = '0;
        if (state == S_OUT) begin
            if (mode) begin
                if (oidx == XW'(0))      out = OW'(st_max);
                else if (oidx == XW'(1)) out = OW'(st_min);
                else                     out = OW'(st_max - st_min);
            end else begin
                for (int unsigned m = 0; m < NW; m++)
                    if (oidx == XW'(m)) out = {acc_re[m], acc_im[m]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode   <= 1'b0;
            cnt    <= '0;
            ci     <= '0;
            cj     <= '0;
            oidx   <= '0;
            st_max <= 4'd0;
            st_min <= 4'd15;
            for (int unsigned m = 0; m < NB; m++) beat_buf[m] <= '0;
            for (int unsigned m = 0; m < NW; m++) begin
                acc_re[m] <= '0;
                acc_im[m] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mode <= in_mode;
                        cnt  <= CW'(1);
                        if (in_mode) begin
                            st_max <= st_max_nxt;
                            st_min <= st_min_nxt;
                        end else begin
                            beat_buf[0] <= in;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (mode) begin
                            st_max <= st_max_nxt;
                            st_min <= st_min_nxt;
                        end else begin
                            for (int unsigned m = 0; m < NB; m++)
                                if (cnt == CW'(m)) beat_buf[m] <= in;
                            // Saturate one past full so over-long bursts still flag err.
                            if (cnt != CNT_SAT) cnt <= cnt + CW'(1);
                        end
                    end else begin
                        cnt <= '0;
                        if (!mode) begin
                            if (cnt == CNT_FULL) begin
                                ci <= '0;
                                cj <= '0;
                                for (int unsigned m = 0; m < NW; m++) begin
                                    acc_re[m] <= '0;
                                    acc_im[m] <= '0;
                                end
                            end else begin
                                for (int unsigned m = 0; m < NB; m++) beat_buf[m] <= '0;
                            end
                        end
                    end
                end
                S_CALC: begin
                    for (int unsigned m = 0; m < NW; m++) begin
                        if (int'(ci) + int'(cj) == int'(m)) begin
                            acc_re[m] <= acc_re[m] + t_re;
                            acc_im[m] <= acc_im[m] + t_im;
                        end
                    end
                    if (cj == I_LAST) begin
                        cj <= '0;
                        ci <= ci + IW'(1);
                    end else begin
                        cj <= cj + IW'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (oidx == oidx_last) begin
                            oidx   <= '0;
                            st_max <= 4'd0;
                            st_min <= 4'd15;
                        end else begin
                            oidx <= oidx + XW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
